// File: rtl/pipeline_ctrl_n.sv
// Hazard and redirect controller for an N-stage in-order pipeline.
// Produces per-stage stall/flush vectors, a load-use interlock across several
// producer slots, a fetch redirect that is held until fetch can take it, a
// vectored exception redirect with a one-cycle global flush, and a saturating
// count of decode-stall cycles.
module pipeline_ctrl_n #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    PREG_WIDTH   = 6,
    parameter int                    NUM_STAGES   = 5,
    parameter int                    BRANCH_STAGE = 2,
    parameter int                    LOAD_DEPTH   = 1,
    parameter logic [DATA_WIDTH-1:0] EXC_VEC_BASE = 32'h00000180,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    input  logic [NUM_STAGES-1:0]            stage_busy,
    input  logic                             regfile_stall,
    input  logic                             dec_branch,
    input  logic                             dec_rs_en,
    input  logic [PREG_WIDTH-1:0]            dec_rs_addr,
    input  logic                             dec_rt_en,
    input  logic [PREG_WIDTH-1:0]            dec_rt_addr,
    input  logic [LOAD_DEPTH-1:0]            ld_valid,
    input  logic [LOAD_DEPTH*PREG_WIDTH-1:0] ld_waddr,
    input  logic                             br_take,
    input  logic [DATA_WIDTH-1:0]            br_target,
    input  logic                             exc_valid,
    input  logic                             exc_eret,
    input  logic [4:0]                       exc_code,
    input  logic [DATA_WIDTH-1:0]            epc,
    output logic [NUM_STAGES-1:0]            stall,
    output logic [NUM_STAGES-1:0]            flush,
    output logic                             redirect_valid,
    output logic [DATA_WIDTH-1:0]            redirect_target,
    output logic                             global_flush,
    output logic [CNT_WIDTH-1:0]             stall_cycles
);

    logic                  active;
    logic                  load_use;
    logic                  br_go;
    logic [NUM_STAGES-1:0] local_stall;
    logic [NUM_STAGES-1:0] stall_chain;
    logic [NUM_STAGES-1:0] flush_vec;
    logic                  pend_v;
    logic [DATA_WIDTH-1:0] pend_tgt;
    logic                  discard;
    logic [DATA_WIDTH-1:0] exc_target;
    logic [DATA_WIDTH-1:0] exc_offset;

    assign active = ~rst & run;

    // Load-use interlock: decode reads a register that an in-flight load has
    // not yet produced. Register 0 is deliberately not treated specially.
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < LOAD_DEPTH; k++) begin
            if (ld_valid[k] &&
                ((dec_rs_en && dec_rs_addr == ld_waddr[k*PREG_WIDTH +: PREG_WIDTH]) ||
                 (dec_rt_en && dec_rt_addr == ld_waddr[k*PREG_WIDTH +: PREG_WIDTH])))
                load_use = 1'b1;
        end
    end

    // Local stall causes and back-propagation toward fetch; a stage may only
    // inject a bubble when the stage after it is moving.
    always_comb begin
        local_stall    = stage_busy;
        local_stall[1] = stage_busy[1] | regfile_stall | (dec_branch & stage_busy[0]) | load_use;
        stall_chain    = '0;
        stall_chain[NUM_STAGES-1] = local_stall[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--)
            stall_chain[i] = local_stall[i] | stall_chain[i+1];
        flush_vec = '0;
        flush_vec[NUM_STAGES-1] = local_stall[NUM_STAGES-1];
        for (int i = 0; i < NUM_STAGES - 1; i++)
            flush_vec[i] = local_stall[i] & ~stall_chain[i+1];
        // A branch only counts once it is actually leaving its resolve stage.
        br_go = active & br_take & ~stall_chain[BRANCH_STAGE];
        if (br_go) begin
            for (int j = 0; j < BRANCH_STAGE; j++)
                flush_vec[j] = 1'b1;
        end
        if (discard)
            flush_vec[0] = 1'b1;
        if (global_flush)
            flush_vec = '1;
    end

    // Output muxing: halted or in reset freezes every stage and drops redirect.
    always_comb begin
        stall           = '1;
        flush           = '1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        if (active) begin
            stall = stall_chain;
            flush = flush_vec;
            if (br_go) begin
                redirect_valid  = 1'b1;
                redirect_target = br_target;
            end else if (pend_v) begin
                redirect_valid  = 1'b1;
                redirect_target = pend_tgt;
            end
        end
    end

    // Exception vector: base plus cause code scaled by 8, or EPC for ERET.
    always_comb begin
        exc_offset      = '0;
        exc_offset[7:0] = {exc_code, 3'b000};
        exc_target      = exc_eret ? epc : EXC_VEC_BASE + exc_offset;
    end

    // Pending redirect, in-flight discard and global flush state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v       <= 1'b0;
            pend_tgt     <= '0;
            discard      <= 1'b0;
            global_flush <= 1'b0;
        end else begin
            global_flush <= exc_valid & run;
            if (exc_valid && run) begin
                pend_v   <= 1'b1;
                pend_tgt <= exc_target;
            end else if (redirect_valid && stall[0]) begin
                pend_v   <= 1'b1;
                pend_tgt <= redirect_target;
            end else if (redirect_valid) begin
                pend_v   <= 1'b0;
            end
            if (redirect_valid && !stall[0] && stage_busy[0])
                discard <= 1'b1;
            else if (!stage_busy[0])
                discard <= 1'b0;
        end
    end

    // Saturating count of cycles where decode is held while the core runs.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (run && stall[1] && stall_cycles != {CNT_WIDTH{1'b1}})
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl_n.sv
// Directed bench for pipeline_ctrl_n: five stages, branch at stage 2, two
// load slots and a 3-bit stall counter so saturation is reachable.
module tb_pipeline_ctrl_n;

    localparam int DW = 32;
    localparam int PW = 6;
    localparam int NS = 5;
    localparam int LD = 2;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst, run;
    logic [NS-1:0]     stage_busy;
    logic              regfile_stall, dec_branch;
    logic              dec_rs_en, dec_rt_en;
    logic [PW-1:0]     dec_rs_addr, dec_rt_addr;
    logic [LD-1:0]     ld_valid;
    logic [LD*PW-1:0]  ld_waddr;
    logic              br_take;
    logic [DW-1:0]     br_target;
    logic              exc_valid, exc_eret;
    logic [4:0]        exc_code;
    logic [DW-1:0]     epc;
    logic [NS-1:0]     stall, flush;
    logic              redirect_valid;
    logic [DW-1:0]     redirect_target;
    logic              global_flush;
    logic [CW-1:0]     stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_ctrl_n #(
        .DATA_WIDTH(DW), .PREG_WIDTH(PW), .NUM_STAGES(NS), .BRANCH_STAGE(2),
        .LOAD_DEPTH(LD), .EXC_VEC_BASE(32'h00000180), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .stage_busy(stage_busy),
        .regfile_stall(regfile_stall), .dec_branch(dec_branch),
        .dec_rs_en(dec_rs_en), .dec_rs_addr(dec_rs_addr),
        .dec_rt_en(dec_rt_en), .dec_rt_addr(dec_rt_addr),
        .ld_valid(ld_valid), .ld_waddr(ld_waddr),
        .br_take(br_take), .br_target(br_target),
        .exc_valid(exc_valid), .exc_eret(exc_eret), .exc_code(exc_code), .epc(epc),
        .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .global_flush(global_flush), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs are then changed well before the next one.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; stage_busy = '0; regfile_stall = 1'b0; dec_branch = 1'b0;
        dec_rs_en = 1'b0; dec_rs_addr = '0; dec_rt_en = 1'b0; dec_rt_addr = '0;
        ld_valid = '0; ld_waddr = '0; br_take = 1'b0; br_target = '0;
        exc_valid = 1'b0; exc_eret = 1'b0; exc_code = '0; epc = '0;
        tick(); tick();

        // Reset state
        chk("rst_stall", stall, 5'h1F);
        chk("rst_flush", flush, 5'h1F);
        chk("rst_rv", redirect_valid, 1'b0);
        chk("rst_gf", global_flush, 1'b0);
        chk("rst_cnt", stall_cycles, 3'd0);

        rst = 1'b0; settle();
        chk("idle_stall", stall, 5'h00);
        chk("idle_flush", flush, 5'h00);
        chk("idle_rv", redirect_valid, 1'b0);
        tick();
        chk("idle_cnt", stall_cycles, 3'd0);

        // Load-use on rs, slot 0
        ld_valid = 2'b01; ld_waddr = {6'd0, 6'd5}; dec_rs_en = 1'b1; dec_rs_addr = 6'd5; settle();
        chk("lu_rs_stall", stall, 5'b00011);
        chk("lu_rs_flush", flush, 5'b00010);
        tick();
        // Load-use on rt
        dec_rs_en = 1'b0; dec_rt_en = 1'b1; dec_rt_addr = 6'd5; settle();
        chk("lu_rt_stall", stall, 5'b00011);
        tick();
        // Register 0 still interlocks
        ld_waddr = {6'd0, 6'd0}; dec_rt_addr = 6'd0; settle();
        chk("lu_r0_stall", stall, 5'b00011);
        tick();
        // No match
        dec_rt_addr = 6'd6; settle();
        chk("lu_miss_stall", stall, 5'b00000);
        chk("lu_miss_flush", flush, 5'b00000);
        tick();
        chk("lu_cnt", stall_cycles, 3'd3);
        // Slot 1 producer, rs disabled but matching address must not trigger
        ld_valid = 2'b10; ld_waddr = {6'd9, 6'd0}; dec_rt_en = 1'b0; dec_rs_addr = 6'd9; settle();
        chk("lu_en_off", stall, 5'b00000);
        dec_rs_en = 1'b1; settle();
        chk("lu_slot1", stall, 5'b00011);
        ld_valid = '0; dec_rs_en = 1'b0;

        // Regfile conflict and branch-in-decode waiting on fetch
        regfile_stall = 1'b1; settle();
        chk("rf_stall", stall, 5'b00011);
        chk("rf_flush", flush, 5'b00010);
        regfile_stall = 1'b0; dec_branch = 1'b1; stage_busy = 5'b00001; settle();
        chk("db_stall", stall, 5'b00011);
        chk("db_flush", flush, 5'b00010);
        dec_branch = 1'b0; stage_busy = '0;

        // Memory stage busy for three cycles
        stage_busy = 5'b01000; settle();
        chk("mem_stall", stall, 5'b01111);
        chk("mem_flush", flush, 5'b01000);
        tick(); tick(); tick();
        chk("mem_cnt", stall_cycles, 3'd6);
        stage_busy = 5'b10000; settle();
        chk("wb_stall", stall, 5'b11111);
        chk("wb_flush", flush, 5'b10000);
        stage_busy = '0;

        // Branch with fetch stalled
        br_take = 1'b1; br_target = 32'h400; stage_busy = 5'b00001; settle();
        chk("br_rv", redirect_valid, 1'b1);
        chk("br_tgt", redirect_target, 32'h400);
        chk("br_flush", flush, 5'b00011);
        chk("br_stall", stall, 5'b00001);
        tick();
        br_take = 1'b0; settle();
        chk("br_hold_rv", redirect_valid, 1'b1);
        chk("br_hold_tgt", redirect_target, 32'h400);
        chk("br_hold_flush", flush, 5'b00001);
        tick();
        // A live branch overrides the pending target
        br_take = 1'b1; br_target = 32'h800; settle();
        chk("br_override", redirect_target, 32'h800);
        tick();
        br_take = 1'b0; settle();
        chk("br_pend2", redirect_target, 32'h800);
        stage_busy = '0; settle();
        chk("br_acc_rv", redirect_valid, 1'b1);
        chk("br_acc_flush", flush, 5'b00000);
        tick();
        chk("br_done_rv", redirect_valid, 1'b0);
        chk("br_done_tgt", redirect_target, 32'h0);
        chk("br_cnt", stall_cycles, 3'd6);

        // Branch stalled by its own stage is ignored
        br_take = 1'b1; stage_busy = 5'b00100; settle();
        chk("brst_rv", redirect_valid, 1'b0);
        chk("brst_flush", flush, 5'b00100);
        br_take = 1'b0; stage_busy = '0;

        // Exception and branch in the same cycle
        br_take = 1'b1; br_target = 32'h400; exc_valid = 1'b1; exc_code = 5'd8; settle();
        chk("exbr_tgt", redirect_target, 32'h400);
        tick();
        br_take = 1'b0; exc_valid = 1'b0; settle();
        chk("exc_gf", global_flush, 1'b1);
        chk("exc_flush", flush, 5'h1F);
        chk("exc_rv", redirect_valid, 1'b1);
        chk("exc_tgt", redirect_target, 32'h1C0);
        tick();
        chk("exc_gf_clr", global_flush, 1'b0);
        chk("exc_rv_clr", redirect_valid, 1'b0);
        chk("exc_flush_clr", flush, 5'h00);

        // ERET
        exc_valid = 1'b1; exc_eret = 1'b1; epc = 32'hBFC0_0100; tick();
        exc_valid = 1'b0; exc_eret = 1'b0; settle();
        chk("eret_gf", global_flush, 1'b1);
        chk("eret_tgt", redirect_target, 32'hBFC0_0100);
        tick();
        chk("eret_rv_clr", redirect_valid, 1'b0);

        // Halt mid-branch; exception during halt is ignored
        br_take = 1'b1; br_target = 32'h400; settle();
        chk("halt_pre_rv", redirect_valid, 1'b1);
        run = 1'b0; exc_valid = 1'b1; stage_busy = 5'b01000; settle();
        chk("halt_stall", stall, 5'h1F);
        chk("halt_flush", flush, 5'h1F);
        chk("halt_rv", redirect_valid, 1'b0);
        tick(); tick();
        chk("halt_cnt", stall_cycles, 3'd6);
        run = 1'b1; exc_valid = 1'b0; br_take = 1'b0; stage_busy = '0; settle();
        chk("halt_gf", global_flush, 1'b0);
        chk("halt_after_rv", redirect_valid, 1'b0);

        // Counter saturation
        stage_busy = 5'b01000; tick(); tick(); tick();
        chk("cnt_sat", stall_cycles, 3'd7);
        stage_busy = '0;

        // Reset while a redirect is pending
        br_take = 1'b1; br_target = 32'h400; stage_busy = 5'b00001; tick();
        br_take = 1'b0; settle();
        chk("rp_pend_rv", redirect_valid, 1'b1);
        rst = 1'b1; exc_valid = 1'b1; settle();
        chk("rp_rst_rv", redirect_valid, 1'b0);
        tick();
        rst = 1'b0; exc_valid = 1'b0; stage_busy = '0; settle();
        chk("rp_rv", redirect_valid, 1'b0);
        chk("rp_cnt", stall_cycles, 3'd0);
        chk("rp_gf", global_flush, 1'b0);
        chk("rp_flush", flush, 5'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
